rsa_exp_ctrl: RTL and testbench

Parametrised RSA modular-exponentiation controller that sequences the Montgomery precompute engines and the word-serial exponentiation core. It replaces the fixed 4096/64 top level. It adds:
- a proper `start`/`busy`/`done` handshake;
- full synchronous reset of every state element;
- correctly indexed result assembly;
- an optional precompute cache for back-to-back operations under one modulus.

It sits between the host/bus wrapper and the `rtMod`, `modInv` and `ModExp` instances.

---
 rtl/rsa_exp_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_rsa_exp_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: sequences the Montgomery precompute engines (rtMod, modInv)
// and the word-serial exponentiation core for one RSA modular exponentiation.
// Handshake: start (sampled in IDLE) -> busy ... done pulse with cypher valid.
// Optional feature: define RSA_PRECOMP_CACHE_EN to keep R mod n, R^2 mod n
// and -n^-1 across jobs and skip the precompute when the modulus is unchanged.
module rsa_exp_ctrl #(
  parameter int RSA_WIDTH  = 4096,
  parameter int WORD_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [RSA_WIDTH-1:0]  message,
  input  logic [RSA_WIDTH-1:0]  exponent,
  input  logic [RSA_WIDTH-1:0]  modulus,
  output logic                  busy,
  output logic                  done,
  output logic [RSA_WIDTH-1:0]  cypher,
  output logic                  pre_go,
  output logic                  pre_mode,
  input  logic                  pre_done,
  input  logic [RSA_WIDTH-1:0]  pre_result,
  output logic                  inv_go,
  input  logic                  inv_valid,
  input  logic [WORD_WIDTH-1:0] inv_result,
  output logic                  core_load,
  output logic [WORD_WIDTH-1:0] m_word,
  output logic [WORD_WIDTH-1:0] e_word,
  output logic [WORD_WIDTH-1:0] n_word,
  output logic [WORD_WIDTH-1:0] r_word,
  output logic [WORD_WIDTH-1:0] t_word,
  output logic [WORD_WIDTH-1:0] nprime0,
  output logic                  core_start,
  input  logic                  core_res_valid,
  input  logic [WORD_WIDTH-1:0] core_res_word
);

  localparam int NWORDS = RSA_WIDTH / WORD_WIDTH;
  localparam int CW     = $clog2(NWORDS + 1);
  localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] IDX_LAST = CW'(NWORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CALC_R,
    CALC_T,
    CALC_N0,
    LOAD,
    COMPUTE,
    READ
  } state_t;

  state_t                 state;
  logic [CW-1:0]          idx;
  logic [CW-1:0]          idx_inc;
  logic [IW-1:0]          ld_ptr;
  logic                   load_next;
  logic                   cache_hit;
  logic                   pre_fire;
  logic                   inv_fire;
  logic                   res_fire;
  logic [RSA_WIDTH-1:0]   r_reg;
  logic [RSA_WIDTH-1:0]   t_reg;

  // Word-indexed views of the operands; element i is bits [i*WORD_WIDTH +: WORD_WIDTH].
  logic [NWORDS-1:0][WORD_WIDTH-1:0] msg_w;
  logic [NWORDS-1:0][WORD_WIDTH-1:0] exp_w;
  logic [NWORDS-1:0][WORD_WIDTH-1:0] mod_w;
  logic [NWORDS-1:0][WORD_WIDTH-1:0] r_w;
  logic [NWORDS-1:0][WORD_WIDTH-1:0] t_w;
  logic [NWORDS-1:0][WORD_WIDTH-1:0] shadow;

  assign msg_w = message;
  assign exp_w = exponent;
  assign mod_w = modulus;
  assign r_w   = r_reg;
  assign t_w   = t_reg;

  // A completion is only honoured from the cycle after its own go strobe.
  assign pre_fire = pre_done       & ~pre_go;
  assign inv_fire = inv_valid      & ~inv_go;
  assign res_fire = core_res_valid & ~core_start;

`ifdef RSA_PRECOMP_CACHE_EN
  logic                 cache_valid;
  logic [RSA_WIDTH-1:0] cache_tag;

  assign cache_hit = cache_valid && (modulus == cache_tag);

  // Remember which modulus the held r/t/nprime0 values belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
    end else if (state == CALC_N0 && inv_fire) begin
      cache_valid <= 1'b1;
      cache_tag   <= modulus;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Decide whether a word goes onto the core bus next cycle, and which one.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    load_next = 1'b0;
    ld_ptr    = '0;
    idx_inc   = idx + CW'(1);
    unique case (state)
      IDLE:    load_next = start && cache_hit;
      CALC_N0: load_next = inv_fire;
      LOAD: begin
        load_next = (idx != IDX_LAST);
        ld_ptr    = idx_inc[IW-1:0];
      end
      default: load_next = 1'b0;
    endcase
  end

  // Job sequencer with all handshake outputs registered.
  // NOTE: state is updated with non-blocking assignments so every branch sees
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cypher     <= '0;
      pre_go     <= 1'b0;
      pre_mode   <= 1'b0;
      inv_go     <= 1'b0;
      core_load  <= 1'b0;
      core_start <= 1'b0;
      m_word     <= '0;
      e_word     <= '0;
      n_word     <= '0;
      r_word     <= '0;
      t_word     <= '0;
      nprime0    <= '0;
      r_reg      <= '0;
      t_reg      <= '0;
      idx        <= '0;
      // NOTE: the result shadow is plain flops, so it is cleared like any other state.
      shadow     <= '0;
    end else begin
      pre_go     <= 1'b0;
      inv_go     <= 1'b0;
      core_start <= 1'b0;
      done       <= 1'b0;
      core_load  <= load_next;

      if (load_next) begin
        m_word <= msg_w[ld_ptr];
        e_word <= exp_w[ld_ptr];
        n_word <= mod_w[ld_ptr];
        r_word <= r_w[ld_ptr];
        t_word <= t_w[ld_ptr];
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            idx  <= '0;
            if (cache_hit) begin
              state <= LOAD;
            end else begin
              pre_go   <= 1'b1;
              pre_mode <= 1'b0;
              state    <= CALC_R;
            end
          end
        end
        CALC_R: begin
          if (pre_fire) begin
            r_reg    <= pre_result;
            pre_go   <= 1'b1;
            pre_mode <= 1'b1;
            state    <= CALC_T;
          end
        end
        CALC_T: begin
          if (pre_fire) begin
            t_reg  <= pre_result;
            inv_go <= 1'b1;
            state  <= CALC_N0;
          end
        end
        CALC_N0: begin
          if (inv_fire) begin
            nprime0 <= inv_result;
            idx     <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          // idx is the word currently on the bus; the last one triggers core_start.
          if (idx == IDX_LAST) begin
            core_start <= 1'b1;
            idx        <= '0;
            state      <= COMPUTE;
          end else begin
            idx <= idx_inc;
          end
        end
        COMPUTE: begin
          if (res_fire) begin
            shadow[idx[IW-1:0]] <= core_res_word;
            if (idx == IDX_LAST) begin
              state <= READ;
            end else begin
              idx <= idx_inc;
            end
          end
        end
        READ: begin
          cypher <= shadow;
          done   <= 1'b1;
          busy   <= 1'b0;
          idx    <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// tb_rsa_exp_ctrl: table-driven jobs through behavioural rtMod/modInv/core
// models, scoreboard of expected cyphers, plus hand-written reset sequences.
module tb_rsa_exp_ctrl;

  localparam int RW = 128;
  localparam int WW = 32;
  localparam int NW = RW / WW;
  localparam int PRE_LAT  = 3;
  localparam int INV_LAT  = 2;
  localparam int CORE_LAT = 4;
`ifdef RSA_PRECOMP_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start;
  logic [RW-1:0] message, exponent, modulus;
  logic          busy, done;
  logic [RW-1:0] cypher;
  logic          pre_go, pre_mode;
  logic          pre_done = 1'b0;
  logic [RW-1:0] pre_result = '0;
  logic          inv_go;
  logic          inv_valid = 1'b0;
  logic [WW-1:0] inv_result = '0;
  logic          core_load;
  logic [WW-1:0] m_word, e_word, n_word, r_word, t_word, nprime0;
  logic          core_start;
  logic          core_res_valid = 1'b0;
  logic [WW-1:0] core_res_word = '0;

  always #5 clk = ~clk;

  rsa_exp_ctrl #(.RSA_WIDTH(RW), .WORD_WIDTH(WW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .message(message), .exponent(exponent), .modulus(modulus),
    .busy(busy), .done(done), .cypher(cypher),
    .pre_go(pre_go), .pre_mode(pre_mode), .pre_done(pre_done), .pre_result(pre_result),
    .inv_go(inv_go), .inv_valid(inv_valid), .inv_result(inv_result),
    .core_load(core_load), .m_word(m_word), .e_word(e_word), .n_word(n_word),
    .r_word(r_word), .t_word(t_word), .nprime0(nprime0), .core_start(core_start),
    .core_res_valid(core_res_valid), .core_res_word(core_res_word)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [RW-1:0] mod_pow2(input int k, input logic [RW-1:0] n);
    logic [RW-1:0] r;
    r = RW'(1) % n;
    for (int i = 0; i < k; i++) r = (r << 1) % n;
    return r;
  endfunction

  function automatic logic [RW-1:0] modexp(input logic [RW-1:0] m, input logic [RW-1:0] e,
                                           input logic [RW-1:0] n);
    logic [RW-1:0] b, r;
    b = m % n;
    r = RW'(1) % n;
    for (int i = 0; i < RW; i++) begin
      if (e[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r;
  endfunction

  function automatic logic [WW-1:0] neg_inv(input logic [WW-1:0] n0);
    logic [WW-1:0] x;
    x = WW'(1);
    for (int i = 0; i < 5; i++) x = x * (WW'(2) - n0 * x);
    return WW'(0) - x;
  endfunction

  // ---------------- job context shared with the models ----------------
  logic [RW-1:0] cur_m = '0, cur_e = '0, cur_n = '0;
  bit            word_order = 1'b0;
  bit            glitch = 1'b0;
  int            cyc = 0;
  int            last_valid_cyc = 0;
  int            c_pre = 0, c_inv = 0, c_load = 0, c_cstart = 0, c_done = 0;

  always @(posedge clk) cyc++;

  // Strobe counters.
  always @(negedge clk) begin
    if (pre_go)     c_pre++;
    if (inv_go)     c_inv++;
    if (core_load)  c_load++;
    if (core_start) c_cstart++;
    if (done)       c_done++;
  end

  // rtMod model; with glitch set it also fakes a completion in the go cycle.
  bit pre_act = 1'b0;
  bit pre_mode_q = 1'b0;
  int pre_cnt = 0;
  always @(negedge clk) begin
    pre_done   = 1'b0;
    pre_result = '0;
    if (reset) pre_act = 1'b0;
    else if (pre_go) begin
      if (glitch) begin
        pre_done   = 1'b1;
        pre_result = '1;
      end
      pre_act = 1'b1; pre_cnt = PRE_LAT; pre_mode_q = pre_mode;
    end else if (pre_act) begin
      if (pre_cnt == 0) begin
        pre_done   = 1'b1;
        pre_result = pre_mode_q ? mod_pow2(2 * RW, cur_n) : mod_pow2(RW, cur_n);
        pre_act    = 1'b0;
      end else pre_cnt--;
    end
  end

  // modInv model.
  bit inv_act = 1'b0;
  int inv_cnt = 0;
  always @(negedge clk) begin
    inv_valid  = 1'b0;
    inv_result = '0;
    if (reset) inv_act = 1'b0;
    else if (inv_go) begin
      if (glitch) begin
        inv_valid  = 1'b1;
        inv_result = '1;
      end
      inv_act = 1'b1; inv_cnt = INV_LAT;
    end else if (inv_act) begin
      if (inv_cnt == 0) begin
        inv_valid  = 1'b1;
        inv_result = neg_inv(cur_n[WW-1:0]);
        inv_act    = 1'b0;
      end else inv_cnt--;
    end
  end

  // Exponentiation core model: captures loaded words, checks them, returns the result LSW first.
  logic [NW-1:0][WW-1:0] cap_m, cap_e, cap_n, cap_r, cap_t, res_words;
  int ld_cnt = 0, res_cnt = 0, emit_idx = 0;
  bit res_act = 1'b0, prev_load = 1'b0;
  always @(negedge clk) begin
    core_res_valid = 1'b0;
    core_res_word  = '0;
    if (reset) begin
      ld_cnt  = 0;
      res_act = 1'b0;
    end else begin
      if (core_load) begin
        if (ld_cnt < NW) begin
          cap_m[ld_cnt[1:0]] = m_word;
          cap_e[ld_cnt[1:0]] = e_word;
          cap_n[ld_cnt[1:0]] = n_word;
          cap_r[ld_cnt[1:0]] = r_word;
          cap_t[ld_cnt[1:0]] = t_word;
        end
        ld_cnt++;
      end
      if (core_start) begin
        if (glitch) begin
          core_res_valid = 1'b1;
          core_res_word  = '1;
        end
        check("core_start_after_last_load", RW'(prev_load), RW'(1));
        check("core_load_count", RW'(ld_cnt), RW'(NW));
        check("loaded_m", cap_m, cur_m);
        check("loaded_e", cap_e, cur_e);
        check("loaded_n", cap_n, cur_n);
        check("loaded_r", cap_r, mod_pow2(RW, cur_n));
        check("loaded_t", cap_t, mod_pow2(2 * RW, cur_n));
        check("nprime0", RW'(nprime0), RW'(neg_inv(cur_n[WW-1:0])));
        if (word_order) res_words = {WW'(4), WW'(3), WW'(2), WW'(1)};
        else            res_words = modexp(cap_m, cap_e, cap_n);
        res_act = 1'b1; res_cnt = CORE_LAT; emit_idx = 0; ld_cnt = 0;
      end else if (res_act) begin
        if (res_cnt > 0) res_cnt--;
        else begin
          core_res_valid = 1'b1;
          core_res_word  = res_words[emit_idx[1:0]];
          last_valid_cyc = cyc;
          emit_idx++;
          if (emit_idx == NW) res_act = 1'b0;
        end
      end
    end
    prev_load = core_load;
  end

  // ---------------- scoreboard and cache model ----------------
  logic [RW-1:0] exp_q[$];
  bit            sb_valid = 1'b0;
  logic [RW-1:0] sb_tag = '0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_job(input string name, input logic [RW-1:0] m, input logic [RW-1:0] e,
                         input logic [RW-1:0] n, input logic [RW-1:0] exp, input bit ord,
                         input bit glt, input bit poke);
    bit hit, got, poked1, poked2;
    logic [RW-1:0] want;
    hit = CACHE_EN && sb_valid && (n == sb_tag);
    cur_m = m; cur_e = e; cur_n = n; word_order = ord; glitch = glt;
    message = m; exponent = e; modulus = n;
    c_pre = 0; c_inv = 0; c_load = 0; c_cstart = 0; c_done = 0;
    exp_q.push_back(exp);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, ":busy_after_start"}, RW'(busy), RW'(1));
    check({name, ":pre_go_after_start"}, RW'(pre_go), RW'(!hit));
    got = 1'b0; poked1 = 1'b0; poked2 = 1'b0;
    for (int t = 0; t < 2000 && !got; t++) begin
      if (done) got = 1'b1;
      else begin
        start = 1'b0;
        if (poke && busy && pre_mode && !poked1) begin
          start = 1'b1; poked1 = 1'b1;
        end else if (poke && core_load && !poked2) begin
          start = 1'b1; poked2 = 1'b1;
        end
        tick();
      end
    end
    start = 1'b0;
    check({name, ":done_seen"}, RW'(got), RW'(1));
    want = exp_q.pop_front();
    if (got) begin
      check({name, ":cypher"}, cypher, want);
      check({name, ":busy_low_with_done"}, RW'(busy), RW'(0));
      check({name, ":done_latency"}, RW'(cyc - last_valid_cyc), RW'(2));
      repeat (3) tick();
      check({name, ":done_count"}, RW'(c_done), RW'(1));
      check({name, ":stays_idle"}, RW'(busy), RW'(0));
      check({name, ":cypher_held"}, cypher, want);
      check({name, ":pre_go_count"}, RW'(c_pre), hit ? RW'(0) : RW'(2));
      check({name, ":inv_go_count"}, RW'(c_inv), hit ? RW'(0) : RW'(1));
      check({name, ":load_count"}, RW'(c_load), RW'(NW));
      check({name, ":core_start_count"}, RW'(c_cstart), RW'(1));
      if (!hit) begin
        sb_valid = 1'b1;
        sb_tag   = n;
      end
    end else begin
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      sb_valid = 1'b0;
      tick();
    end
    glitch = 1'b0;
  endtask

  typedef struct {
    logic [RW-1:0] m, e, n, exp;
    bit            ord, glt, poke;
  } vec_t;

  vec_t vecs[6];
  bit   reached;
  int   loads_seen;

  initial begin
    vecs[0] = '{m: 5, e: 3, n: 33, exp: 26, ord: 0, glt: 0, poke: 0};
    vecs[1] = '{m: 5, e: 3, n: 33, exp: {32'h4, 32'h3, 32'h2, 32'h1}, ord: 1, glt: 0, poke: 0};
    vecs[2] = '{m: 7, e: 2, n: 33, exp: 16, ord: 0, glt: 0, poke: 1};
    vecs[3] = '{m: 2, e: 5, n: 35, exp: 32, ord: 0, glt: 1, poke: 0};
    vecs[4] = '{m: 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C, e: 17,
                n: 128'h0000_0003_0000_0007, exp: '0, ord: 0, glt: 0, poke: 0};
    vecs[4].exp = modexp(vecs[4].m, vecs[4].e, vecs[4].n);
    vecs[5] = '{m: 10, e: 7, n: 33, exp: 10, ord: 0, glt: 1, poke: 1};

    // Reset held with start high: reset must win.
    reset = 1'b1; start = 1'b1;
    message = '0; exponent = '0; modulus = '0;
    repeat (3) tick();
    check("reset_flags", RW'({busy, done, pre_go, pre_mode, inv_go, core_load, core_start}), RW'(0));
    check("reset_cypher", cypher, '0);
    check("reset_words_a", {m_word, e_word, n_word, r_word}, '0);
    check("reset_words_b", RW'({t_word, nprime0}), RW'(0));
    reset = 1'b0; start = 1'b0;
    tick();
    check("idle_after_reset", RW'({busy, pre_go}), RW'(0));

    for (int i = 0; i < 6; i++)
      run_job($sformatf("vec%0d", i), vecs[i].m, vecs[i].e, vecs[i].n, vecs[i].exp,
              vecs[i].ord, vecs[i].glt, vecs[i].poke);

    // Reset asserted in the second LOAD cycle of a job.
    cur_m = 5; cur_e = 3; cur_n = 33; message = 5; exponent = 3; modulus = 33;
    start = 1'b1;
    tick();
    start = 1'b0;
    reached = 1'b0; loads_seen = 0;
    for (int t = 0; t < 500 && !reached; t++) begin
      if (core_load) loads_seen++;
      if (loads_seen == 2) reached = 1'b1;
      else tick();
    end
    check("mid_reset:second_load_reached", RW'(reached), RW'(1));
    reset = 1'b1;
    tick();
    check("mid_reset:flags", RW'({busy, done, pre_go, pre_mode, inv_go, core_load, core_start}), RW'(0));
    check("mid_reset:cypher", cypher, '0);
    check("mid_reset:words_a", {m_word, e_word, n_word, r_word}, '0);
    check("mid_reset:words_b", RW'({t_word, nprime0}), RW'(0));
    reset = 1'b0;
    sb_valid = 1'b0;
    tick();
    run_job("after_reset", 7, 2, 33, 16, 0, 0, 0);

    // Cache sequence: same modulus twice, then a new modulus.
    run_job("cache_a", 2, 5, 35, 32, 0, 0, 0);
    run_job("cache_n33_first", 5, 3, 33, 26, 0, 0, 0);
    run_job("cache_n33_second", 5, 3, 33, 26, 0, 0, 0);
    run_job("cache_n35", 2, 5, 35, 32, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
